// File: rtl/xarb_wrr_lock.sv
// rtl/xarb_wrr_lock.sv - weighted round-robin arbiter with packet lock
module xarb_wrr_lock #(
  parameter  int N  = 4,
  parameter  int WW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  input  logic            ready,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_vld,
  output logic            beat
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gnt_id_q;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win_id;
  logic [WW-1:0] credit [N];
  logic [N-1:0]  elig;
  logic [N-1:0]  cand;
  logic          reload;
  logic          pkt_end;
  int            arb_idx;

  // Eligible set: requesters with credit left, or all requesters once the round is spent
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req[i] && (credit[i] != '0);
    end
    reload = (elig == '0);
    cand   = reload ? req : elig;
  end

  // Rotating priority search starting at ptr; walked backwards so the nearest hit wins
  always_comb begin
    win_id  = '0;
    arb_idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      arb_idx = int'(ptr) + k;
      if (arb_idx >= N) begin
        arb_idx = arb_idx - N;
      end
      if (cand[IW'(arb_idx)]) begin
        win_id = IW'(arb_idx);
      end
    end
  end

  assign pkt_end = beat & last[gnt_id_q];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: lock on arbitration, release on the last beat of the packet
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req)   state_nxt = ST_BUSY;
      ST_BUSY: if (pkt_end) state_nxt = ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: grant comes straight from registers, beat qualifies the locked owner
  always_comb begin
    gnt     = gnt_q;
    gnt_id  = gnt_id_q;
    gnt_vld = |gnt_q;
    beat    = gnt_vld & req[gnt_id_q] & ready;
  end

  // Grant, pointer and credit bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr      <= '0;
      for (int i = 0; i < N; i++) begin
        credit[i] <= '0;
      end
    end else if (state == ST_IDLE && |req) begin
      gnt_q    <= N'(1) << win_id;
      gnt_id_q <= win_id;
      if (reload) begin
        for (int i = 0; i < N; i++) begin
          credit[i] <= (weight[i*WW +: WW] == '0) ? WW'(1) : weight[i*WW +: WW];
        end
      end
    end else if (pkt_end) begin
      gnt_q <= '0;
      if (credit[gnt_id_q] != '0) begin
        credit[gnt_id_q] <= credit[gnt_id_q] - WW'(1);
      end
      // Spent initiator hands priority to its neighbour; otherwise it keeps the head
      if (credit[gnt_id_q] <= WW'(1)) begin
        ptr <= (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);
      end else begin
        ptr <= gnt_id_q;
      end
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));
  a_gnt_stable:  assert property (@(posedge clk) disable iff (!rstn)
                                  (state == ST_BUSY && !pkt_end) |=> $stable(gnt));
  a_beat_vld:    assert property (@(posedge clk) disable iff (!rstn) beat |-> gnt_vld);
`endif

endmodule
